// File: rtl/add_iter_ctrl.sv
// Multi-cycle add/subtract sequencer: repeats a bitwise half-adder pass
// (sum = a^b, carry = a&b) until the shifted carry vector is zero.

module add #(
   parameter int N = 16
) (
   input  logic [N-1:0] rs1_reg,
   input  logic [N-1:0] rs2_reg,
   output logic [N-1:0] add_rd,
   output logic [N-1:0] co
);
   assign add_rd = rs1_reg ^ rs2_reg;
   assign co     = rs1_reg & rs2_reg;
endmodule

// Handshake: a request transfers on the rising edge where req_valid && req_ready;
// a result transfers on the rising edge where res_valid && res_ready. Neither
// valid may depend combinationally on the matching ready.
module add_iter_ctrl #(
   parameter int N     = 16,
   parameter int CNT_W = $clog2(N+2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [N-1:0]     op_a,
   input  logic [N-1:0]     op_b,
   input  logic             op_sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [N-1:0]     result,
   output logic             cout,
   output logic             ovf,
   output logic [CNT_W-1:0] iter_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   x;
   logic [N-1:0]   y;
   logic           first;
   logic           sub_r;
   logic           a_msb;
   logic           b_msb;
   logic [N-1:0]   add_rd;
   logic [N-1:0]   co;
   logic           inj;
   logic [N-1:0]   y_n;
   logic           accept;
   logic           carry_zero;

   add #(.N(N)) u_add (
      .rs1_reg (x),
      .rs2_reg (y),
      .add_rd  (add_rd),
      .co      (co)
   );

   // The +1 of two's-complement subtract enters as bit 0 of the first carry vector.
   assign inj        = first && sub_r;
   assign y_n        = {co[N-2:0], inj};
   assign carry_zero = (y_n == '0);
   assign accept     = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid)  state_nxt = ITER;
         ITER:    if (carry_zero) state_nxt = DONE;
         DONE:    if (res_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      res_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x        <= '0;
         y        <= '0;
         first    <= 1'b0;
         sub_r    <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
         iter_cnt <= '0;
      end else if (accept) begin
         x        <= op_a;
         y        <= op_sub ? ~op_b : op_b;
         a_msb    <= op_a[N-1];
         b_msb    <= op_sub ? ~op_b[N-1] : op_b[N-1];
         first    <= 1'b1;
         sub_r    <= op_sub;
         cout     <= 1'b0;
         iter_cnt <= '0;
      end else if (state == ITER) begin
         x        <= add_rd;
         y        <= y_n;
         // At most one carry leaves bit N-1 over the whole operation.
         cout     <= cout | co[N-1];
         iter_cnt <= iter_cnt + CNT_W'(1);
         first    <= 1'b0;
         if (carry_zero) begin
            result <= add_rd;
            ovf    <= (a_msb == b_msb) && (add_rd[N-1] != a_msb);
         end
      end
   end

endmodule

// File: tb/tb_add_iter_ctrl.sv
// Scoreboard bench for add_iter_ctrl: reference sums queued at request accept,
// compared when the result handshake fires.

module tb_add_iter_ctrl;

   localparam int N     = 16;
   localparam int CNT_W = $clog2(N+2);
   localparam int W     = CNT_W + 2 + N;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [N-1:0]     op_a;
   logic [N-1:0]     op_b;
   logic             op_sub;
   logic             res_valid;
   logic             res_ready;
   logic [N-1:0]     result;
   logic             cout;
   logic             ovf;
   logic [CNT_W-1:0] iter_cnt;
   logic             busy;

   logic [W-1:0] exp_q[$];
   int           n_cmp;
   int           n_bad;

   add_iter_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .iter_cnt  (iter_cnt),
      .busy      (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference: {iter (0 = unchecked), ovf, cout, result}
   function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic sub, input int it);
      logic [N-1:0] yv;
      logic [N:0]   s;
      logic         v;
      yv = sub ? ~b : b;
      s  = {1'b0, a} + {1'b0, yv} + {{N{1'b0}}, sub};
      v  = (a[N-1] == yv[N-1]) && (s[N-1] != a[N-1]);
      return {CNT_W'(it), v, s[N], s[N-1:0]};
   endfunction

   // driver: inputs change 1 time unit after the rising edge
   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                       input int it);
      int n;
      req_valid = 1'b1;
      op_a      = a;
      op_b      = b;
      op_sub    = sub;
      n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      op_a      = $urandom_range(0, 65535);
      op_b      = $urandom_range(0, 65535);
      exp_q.push_back(model(a, b, sub, it));
   endtask

   task automatic wait_res_valid(output int k);
      k = 0;
      while (!res_valid && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && busy) assert (iter_cnt <= CNT_W'(N+1));
      if (rst_n && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("result", 32'(result), 32'(e[N-1:0]));
            chk("cout",   32'(cout),   32'(e[N]));
            chk("ovf",    32'(ovf),    32'(e[N+1]));
            chk("iter_range", 32'((iter_cnt >= 1) && (iter_cnt <= CNT_W'(N+1))), 32'd1);
            if (e[W-1:N+2] != '0) chk("iter_cnt", 32'(iter_cnt), 32'(e[W-1:N+2]));
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_result"},    32'(result),    32'd0);
      chk({tag, "_cout"},      32'(cout),      32'd0);
      chk({tag, "_ovf"},       32'(ovf),       32'd0);
      chk({tag, "_iter_cnt"},  32'(iter_cnt),  32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int k;
      int nb;
      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_sub    = 1'b0;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // latency: res_valid high after the 4th ITER edge
      send(16'h0005, 16'h0003, 1'b0, 4);
      wait_res_valid(k);
      chk("latency_5p3", 32'(k), 32'd4);
      @(posedge clk); #1;

      // busy spans 4 ITER cycles plus 1 DONE cycle
      send(16'h0005, 16'h0003, 1'b0, 4);
      nb = 0;
      k  = 0;
      do begin
         @(negedge clk);
         if (busy) nb++;
         k++;
      end while (busy && k < 100);
      chk("busy_cycles_5p3", 32'(nb), 32'd5);
      @(posedge clk); #1;

      send(16'hFFFF, 16'h0001, 1'b0, 16);
      send(16'h7FFF, 16'h0001, 1'b0, 0);
      send(16'h1234, 16'h0000, 1'b0, 1);
      send(16'h0005, 16'h0003, 1'b1, 0);
      send(16'h0003, 16'h0005, 1'b1, 0);
      send(16'h8000, 16'h0001, 1'b1, 0);
      send(16'h0000, 16'h0000, 1'b1, 0);
      send(16'h0000, 16'h0001, 1'b1, 0);

      for (int i = 0; i < 25; i++)
         send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
              1'($urandom_range(0, 1)), 0);
      wait_res_valid(k);
      @(posedge clk); @(posedge clk); #1;

      // backpressure: result held for 10 cycles, a request pulse is ignored
      res_ready = 1'b0;
      send(16'h1111, 16'h2222, 1'b0, 0);
      wait_res_valid(k);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            req_valid = 1'b1;
            op_a      = 16'hFFFF;
            op_b      = 16'hFFFF;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         chk("bp_result",    32'(result),    32'h3333);
         chk("bp_cout",      32'(cout),      32'd0);
         chk("bp_ovf",       32'(ovf),       32'd0);
         chk("bp_res_valid", 32'(res_valid), 32'd1);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_res_valid", 32'(res_valid), 32'd0);
      chk("bp_release_req_ready", 32'(req_ready), 32'd1);
      chk("bp_release_q_empty",   32'(exp_q.size()), 32'd0);
      send(16'h0100, 16'h0011, 1'b0, 0);
      wait_res_valid(k);
      @(posedge clk); #1;

      // asynchronous reset in the middle of a long carry chain
      send(16'hFFFF, 16'h0001, 1'b0, 16);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midop_rst");
      exp_q.delete();
      @(posedge clk); #1;
      chk("midop_rst_held_res_valid", 32'(res_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(16'h0002, 16'h0002, 1'b0, 0);
      wait_res_valid(k);
      @(posedge clk); #1;

      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      chk("drain_q_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/add_iter_ctrl.md
Name: add_iter_ctrl

Overview:
Multi-cycle add/subtract sequencer built around one instance of the team's N-bit bitwise half-adder array `add`. Each stage of that array produces add_rd = a^b and co = a&b. The controller feeds add_rd back as the partial sum and {co[N-2:0], inject} back as the carry vector, and repeats until the carry vector is zero. Sits between the CPU execute stage and the ALU result mux behind a valid/ready request/response handshake.

Parameters:
N, 16, operand/result width; passed through to the `add` instance.
CNT_W, $clog2(N+2), width of the iteration counter.

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  operation request
req_ready  output  1  controller can accept a request
op_a  input  N  first operand
op_b  input  N  second operand
op_sub  input  1  1 = op_a - op_b, 0 = op_a + op_b
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
result  output  N  sum/difference
cout  output  1  carry out of bit N-1 (for subtract: 1 = no borrow)
ovf  output  1  signed two's-complement overflow
iter_cnt  output  CNT_W  number of ITER cycles used for the current/last operation
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - result=0, cout=0, ovf=0, iter_cnt=0, res_valid=0, busy=0, req_ready=1.
  - Internal x, y and first-flag are cleared.
- Reset mid-operation aborts immediately; no result is produced.
- One clock domain; all state registers update on the rising edge of clk.
- States: IDLE, ITER, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready:
    - x <= op_a
    - y <= op_sub ? ~op_b : op_b
    - Latch a_msb=op_a[N-1] and b_msb = MSB of the loaded y.
    - first <= 1, sub_r <= op_sub, cout <= 0, iter_cnt <= 0.
    - Go to ITER.
  - Operands are sampled only at this edge; later changes are ignored.
- ITER (req_ready=0). The `add` instance sees rs1_reg=x, rs2_reg=y. Each cycle:
  - inj = first && sub_r.
  - x_n = add_rd; y_n = {co[N-2:0], inj}.
  - x <= x_n, y <= y_n, cout <= cout | co[N-1], iter_cnt <= iter_cnt+1, first <= 0.
  - If y_n == 0: result <= x_n, ovf <= (a_msb==b_msb) && (x_n[N-1]!=a_msb), go to DONE.
- Minimum one ITER cycle per operation, including b=0. Maximum N+1 cycles (subtract with injected +1).
- iter_cnt reaching N+1 with y_n != 0 is a design error; the bench asserts it never happens.
- Total carry-out across all iterations is at most 1, so the sticky OR is exact.
- DONE:
  - res_valid=1.
  - result/cout/ovf/iter_cnt hold stable until res_ready=1.
  - On res_valid && res_ready, go to IDLE; res_valid drops the next cycle.
- No new request is accepted in the cycle DONE hands off. The next accept is earliest one cycle later in IDLE.
- Latency: accept edge, then k ITER edges; res_valid is high after the k-th edge.
- Outputs hold the last result in IDLE until the next DONE overwrites them. iter_cnt is cleared at accept.
- Arithmetic is modulo 2^N. No sign extension; ovf uses signed interpretation.

Test Plan:
- Add 0x0005+0x0003 (N=16), res_ready=1 -> result=0x0008, cout=0, ovf=0, iter_cnt=4, res_valid high 4 edges after accept edge, busy for 5 cycles.
- Add 0xFFFF+0x0001 -> result=0x0000, cout=1, ovf=0, iter_cnt=16 (worst-case add chain).
- Add 0x7FFF+0x0001 -> result=0x8000, cout=0, ovf=1; then add 0x1234+0x0000 -> result=0x1234, iter_cnt=1.
- Sub 0x0005-0x0003 -> result=0x0002, cout=1, ovf=0; sub 0x0003-0x0005 -> result=0xFFFE, cout=0; sub 0x8000-0x0001 -> result=0x7FFF, ovf=1.
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> result/flags stable, req_ready=0, a req_valid pulse is ignored; release -> IDLE next cycle, next request accepted.
- Reset: assert rst_n=0 asynchronously during ITER of 0xFFFF+0x0001 -> outputs reset values immediately (no clock edge needed), no res_valid; after release a fresh 0x0002+0x0002 yields 0x0004.
